// File: rtl/deadlock_idx0_monitor.sv
// deadlock_idx0_monitor
// Simulation-side deadlock detector for one dataflow region. Instance 0 is
// the top process and instance 1 is its pipelined child. The monitor declares
// a deadlock when no instance can make progress and the blocked pattern
// stays unchanged for THRESHOLD consecutive cycles. It then raises a sticky
// block flag and keeps a snapshot of the stalled AXI-Stream channels.
//
// Optional feature: define DEADLOCK_MONITOR_REPORT_EN to print a one-line
// report when block rises. Without the macro no display code is compiled,
// and the ports and timing stay the same.

module deadlock_idx0_monitor #(
    parameter int AXIS_W    = 15,
    parameter int SPLIT     = 2,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [1:0]        inst_idle_sigs,
    input  logic              inst_block_sigs,
    output logic              block,
    output logic [AXIS_W-1:0] block_mask
);

    localparam int              SIG_W  = AXIS_W + 1;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(THRESHOLD);

    logic             blk0;
    logic             blk1;
    logic             stall0;
    logic             stall1;
    logic             any_blk;
    logic             cand;
    logic             frozen;
    logic [SIG_W-1:0] cur_sig;
    logic [SIG_W-1:0] prev_sig;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic             det;
    logic             det_nxt;
    logic             det_rise;

    // Progress analysis: can either instance still move this cycle?
    always_comb begin
        blk1    = |axis_block_sigs[AXIS_W-1:SPLIT];
        blk0    = (|axis_block_sigs[SPLIT-1:0]) | inst_block_sigs;
        stall1  = inst_idle_sigs[1] | blk1;
        // A parent waiting on a child that is active but stalled is also stalled.
        stall0  = inst_idle_sigs[0] | blk0 | (~inst_idle_sigs[1] & stall1);
        any_blk = blk0 | blk1;
        cand    = any_blk & stall0 & stall1;
        cur_sig = {axis_block_sigs, inst_block_sigs};
        frozen  = (cur_sig == prev_sig);
    end

    // Persistence counter: counts cand&frozen cycles, saturates at THRESHOLD,
    // and freezes after detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no path
        // leaves it unassigned and no latch is inferred.
        counter_nxt = counter;
        det_nxt     = det;
        if (!det) begin
            if (!(cand && frozen)) begin
                counter_nxt = '0;
            end else if (counter < THRESH) begin
                counter_nxt = counter + 1'b1;
                if (counter_nxt == THRESH) begin
                    det_nxt = 1'b1;
                end
            end
        end
    end

    assign det_rise = det_nxt & ~det;

    // State registers. Everything here clears as soon as reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge.
        if (!reset) begin
            prev_sig   <= '0;
            counter    <= '0;
            det        <= 1'b0;
            block_mask <= '0;
        end else begin
            prev_sig <= cur_sig;
            counter  <= counter_nxt;
            det      <= det_nxt;
            if (det_rise) begin
                block_mask <= axis_block_sigs;
            end
        end
    end

    assign block = det;

`ifdef DEADLOCK_MONITOR_REPORT_EN
    // One report line on the edge where block rises. det is sticky, so this
    // cannot fire again until the next reset.
    always @(posedge clock) begin
        if (reset && det_rise) begin
            $write("%0t deadlock_idx0_monitor: block_mask=0x%0h stuck bits:",
                   $time, axis_block_sigs);
            for (int i = 0; i < AXIS_W; i++) begin
                if (axis_block_sigs[i]) begin
                    $write(" %0d", i);
                end
            end
            $write("\n");
        end
    end
`endif

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Self-checking bench for deadlock_idx0_monitor.
// Each scenario task pushes the expected outputs for a cycle when it drives
// the stimulus, pops them after the clock edge and compares them inline.

module tb_deadlock_idx0_monitor;

    localparam int AXIS_W    = 15;
    localparam int SPLIT     = 2;
    localparam int THRESHOLD = 16;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic              blk;
        logic [AXIS_W-1:0] mask;
    } exp_t;

    logic              clock;
    logic              reset;
    logic [AXIS_W-1:0] axis_block_sigs;
    logic [1:0]        inst_idle_sigs;
    logic              inst_block_sigs;
    logic              block;
    logic [AXIS_W-1:0] block_mask;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t e;

    deadlock_idx0_monitor #(
        .AXIS_W   (AXIS_W),
        .SPLIT    (SPLIT),
        .THRESHOLD(THRESHOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .block          (block),
        .block_mask     (block_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset pulse placed between edges, with the inputs left quiet.
    task automatic do_reset();
        axis_block_sigs = '0;
        inst_idle_sigs  = 2'b11;
        inst_block_sigs = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        axis_block_sigs = 15'h7fff;
        inst_idle_sigs  = 2'b00;
        inst_block_sigs = 1'b1;
        repeat (3) step();
        sb.push_back('{blk: 1'b0, mask: '0});
        e = sb.pop_front();
        total++;
        if (block !== e.blk || block_mask !== e.mask) begin
            bad++;
            $display("FAIL reset_hold: block=%b mask=%h expected block=%b mask=%h",
                     block, block_mask, e.blk, e.mask);
        end
        do_reset();
        step();
        sb.push_back('{blk: 1'b0, mask: '0});
        e = sb.pop_front();
        total++;
        if (block !== e.blk || block_mask !== e.mask) begin
            bad++;
            $display("FAIL reset_release: block=%b mask=%h expected block=%b mask=%h",
                     block, block_mask, e.blk, e.mask);
        end
    endtask

    task automatic test_idle();
        do_reset();
        inst_idle_sigs  = 2'b11;
        axis_block_sigs = '0;
        for (int k = 1; k <= 100; k++) begin
            sb.push_back('{blk: 1'b0, mask: '0});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL idle cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    // Child channel stalled while both instances are active. block must rise
    // on edge THRESHOLD+1 and then stick after the channel clears.
    task automatic test_child_deadlock();
        do_reset();
        inst_idle_sigs  = 2'b00;
        axis_block_sigs = 15'h0004;
        for (int k = 1; k <= THRESHOLD + 10; k++) begin
            sb.push_back('{blk: (k >= THRESHOLD + 1),
                           mask: (k >= THRESHOLD + 1) ? 15'h0004 : 15'h0000});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL child_deadlock cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
        axis_block_sigs = '0;
        inst_idle_sigs  = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            sb.push_back('{blk: 1'b1, mask: 15'h0004});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL sticky cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
        // An asynchronous reset after detection clears the outputs before any edge.
        #2 reset = 1'b0;
        #1;
        sb.push_back('{blk: 1'b0, mask: '0});
        e = sb.pop_front();
        total++;
        if (block !== e.blk || block_mask !== e.mask) begin
            bad++;
            $display("FAIL reset_after_detect: block=%b mask=%h expected block=%b mask=%h",
                     block, block_mask, e.blk, e.mask);
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_transient();
        do_reset();
        inst_idle_sigs = 2'b00;
        for (int k = 0; k < 200; k++) begin
            axis_block_sigs = ((k / 5) % 2 == 0) ? 15'h0200 : 15'h0000;
            sb.push_back('{blk: 1'b0, mask: '0});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL transient cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    task automatic test_sig_change();
        do_reset();
        inst_idle_sigs  = 2'b00;
        axis_block_sigs = 15'h0004;
        for (int k = 1; k <= 10; k++) begin
            sb.push_back('{blk: 1'b0, mask: '0});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL sig_pre cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
        axis_block_sigs = 15'h0204;
        for (int k = 1; k <= THRESHOLD + 5; k++) begin
            sb.push_back('{blk: (k >= THRESHOLD + 1),
                           mask: (k >= THRESHOLD + 1) ? 15'h0204 : 15'h0000});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL sig_change cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    task automatic test_parent_progress();
        do_reset();
        inst_idle_sigs  = 2'b00;
        axis_block_sigs = 15'h0003;
        for (int k = 1; k <= 100; k++) begin
            sb.push_back('{blk: 1'b0, mask: '0});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL parent_progress cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    // Instance 0 is blocked on a non-AXIS dependency and the child is idle.
    // No channel bit is set, so the captured mask stays zero.
    task automatic test_inst_block();
        do_reset();
        inst_idle_sigs  = 2'b10;
        inst_block_sigs = 1'b1;
        for (int k = 1; k <= THRESHOLD + 4; k++) begin
            sb.push_back('{blk: (k >= THRESHOLD + 1), mask: '0});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL inst_block cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_idle_sigs  = 2'b00;
        axis_block_sigs = 15'h0010;
        repeat (THRESHOLD - 2) step();
        #2 reset = 1'b0;
        #1;
        sb.push_back('{blk: 1'b0, mask: '0});
        e = sb.pop_front();
        total++;
        if (block !== e.blk || block_mask !== e.mask) begin
            bad++;
            $display("FAIL async_reset_low: block=%b mask=%h expected block=%b mask=%h",
                     block, block_mask, e.blk, e.mask);
        end
        #1 reset = 1'b1;
        for (int k = 1; k <= THRESHOLD + 4; k++) begin
            sb.push_back('{blk: (k >= THRESHOLD + 1),
                           mask: (k >= THRESHOLD + 1) ? 15'h0010 : 15'h0000});
            step();
            e = sb.pop_front();
            total++;
            if (block !== e.blk || block_mask !== e.mask) begin
                bad++;
                $display("FAIL async_reset cyc%0d: block=%b mask=%h expected block=%b mask=%h",
                         k, block, block_mask, e.blk, e.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_child_deadlock();
        test_transient();
        test_sig_change();
        test_parent_progress();
        test_inst_block();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
